// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth signed multiplier, one step per clock
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               mult_sel,
    output logic               mult_op
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]     a_sum;
    logic [2*WIDTH+1:0] shifted;

    // Booth recode of {Q[0],q_1}, then arithmetic shift of {A,Q,q_1}; the old q_1 drops off
    always_comb begin
        a_sum = a;
        case ({q[0], q_1})
            2'b10:   a_sum = a - m;
            2'b01:   a_sum = a + m;
            default: a_sum = a;
        endcase
        shifted = {a_sum[WIDTH], a_sum, q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a        <= '0;
            m        <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            cnt      <= '0;
            mult_sel <= 1'b0;
            done     <= 1'b0;
            product  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a        <= '0;
                        q        <= multiplier;
                        q_1      <= 1'b0;
                        m        <= {multiplicand[WIDTH-1], multiplicand};
                        cnt      <= CW'(WIDTH);
                        mult_sel <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    a   <= shifted[2*WIDTH+1:WIDTH+1];
                    q   <= shifted[WIDTH:1];
                    q_1 <= shifted[0];
                    cnt <= cnt - CW'(1);
                    // final step: publish the product so it is valid during the DONE cycle
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        mult_sel <= 1'b0;
                        done     <= 1'b1;
                        product  <= shifted[2*WIDTH:1];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = mult_sel;
    assign mult_op = mult_sel & q[0] & ~q_1;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - self-checking bench for booth_mult_seq
module tb_booth_mult_seq;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           mult_sel;
    logic           mult_op;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product),
        .mult_sel(mult_sel), .mult_op(mult_op)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: phase 0 idle, 1..W computing, W+1 done cycle; product = plain signed multiply
    int             phase = 0;
    int             cyc = 0;
    logic [W-1:0]   mdl_m = '0;
    logic [W-1:0]   mdl_q = '0;
    logic [2*W-1:0] exp_prod = '0;
    int             n_acc = 0;
    int             n_abort = 0;
    int             n_done = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            if (phase >= 1 && phase <= W) n_abort++;
            phase = 0;
            exp_prod = '0;
        end else begin
            cyc++;
            if (phase == 0) begin
                if (start) begin
                    mdl_m = multiplicand;
                    mdl_q = multiplier;
                    phase = 1;
                    n_acc++;
                end
            end else if (phase <= W) begin
                phase++;
                if (phase == W + 1) begin
                    int p;
                    p = $signed(mdl_m) * $signed(mdl_q);
                    exp_prod = p[2*W-1:0];
                end
            end else begin
                phase = 0;
            end
        end
    end

    function automatic logic exp_op(input int ph, input logic [W-1:0] qv);
        logic prev;
        if (ph < 1 || ph > W) return 1'b0;
        prev = (ph == 1) ? 1'b0 : qv[ph-2];
        return qv[ph-1] & ~prev;
    endfunction

    always @(negedge clk) begin
        logic in_calc;
        in_calc = (phase >= 1 && phase <= W);
        chk("busy", busy, in_calc);
        chk("mult_sel", mult_sel, in_calc);
        chk("done", done, phase == W + 1);
        chk("mult_op", mult_op, exp_op(phase, mdl_q));
        chk("product", product, exp_prod);
        if (done === 1'b1) n_done++;
    end

    task automatic do_mult(input logic [W-1:0] mc, input logic [W-1:0] mq,
                           output logic [2*W-1:0] prod, output logic [W-1:0] ops,
                           output int busy_cnt);
        bit got;
        int i;
        @(negedge clk);
        multiplicand = mc;
        multiplier   = mq;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        busy_cnt = 0;
        ops = '0;
        prod = '0;
        got = 0;
        i = 0;
        while (!got && i < 20) begin
            if (done === 1'b1) begin
                got = 1;
                prod = product;
            end else begin
                if (busy === 1'b1) begin
                    if (busy_cnt < W) ops[busy_cnt] = mult_op;
                    busy_cnt++;
                end
                @(negedge clk);
                i++;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [2*W-1:0] prod;
        logic [W-1:0]   ops;
        int             bc;
        int             prev_done;
        int             p;
        logic [W-1:0]   rm, rq;

        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_product", product, 16'h0000);
        chk("reset_mult_op", mult_op, 1'b0);
        rst = 1'b0;

        do_mult(8'd3, 8'd5, prod, ops, bc);
        chk("p_3x5", prod, 16'h000F);
        chk("busy_cycles", bc, 8);
        do_mult(-8'sd7, 8'd6, prod, ops, bc);
        chk("p_m7x6", prod, 16'hFFD6);
        do_mult(8'h80, 8'h80, prod, ops, bc);
        chk("p_m128xm128", prod, 16'h4000);
        do_mult(8'h80, 8'h7F, prod, ops, bc);
        chk("p_m128x127", prod, 16'hC080);
        do_mult(8'h55, 8'h00, prod, ops, bc);
        chk("p_55x0", prod, 16'h0000);
        chk("ops_55x0", ops, 8'h00);
        // steps see {Q[0],q_1} = 00,10,01,10,01,10,01,10 -> subtract on odd steps
        do_mult(8'h01, 8'hAA, prod, ops, bc);
        chk("p_1xAA", prod, 16'hFFAA);
        chk("ops_1xAA", ops, 8'hAA);

        // continuous start with operands changing every cycle
        prev_done = -1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
            @(negedge clk);
            if (done === 1'b1) begin
                if (prev_done >= 0) chk("done_period", cyc - prev_done, W + 2);
                prev_done = cyc;
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // reset during the fourth computing cycle
        @(negedge clk);
        multiplicand = 8'd3;
        multiplier   = 8'd5;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_mult_sel", mult_sel, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_product", product, 16'h0000);
        chk("abort_mult_op", mult_op, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        do_mult(8'hF6, 8'h0C, prod, ops, bc);
        chk("p_after_abort", prod, 16'hFF88);

        for (int n = 0; n < 2000; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rm = W'($urandom);
            rq = W'($urandom);
            do_mult(rm, rq, prod, ops, bc);
            p = $signed(rm) * $signed(rq);
            chk("p_random", prod, p[2*W-1:0]);
        end

        repeat (3) @(negedge clk);
        chk("done_per_start", n_done, n_acc - n_abort);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
